// File: rtl/frac_norm_round_pkg.sv
// Shared widths and FSM encoding for the fraction normalise-and-round block.
package frac_norm_round_pkg;

  // Product width, result fraction width and shift-count width.
  localparam int unsigned ProdW  = 14;
  localparam int unsigned FracW  = ProdW / 2;
  localparam int unsigned ShiftW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StRound,
    StDone
  } state_e;

endpackage

// File: rtl/frac_rne_round.sv
// Round-to-nearest-even on a kept fraction given guard and sticky bits.
module frac_rne_round #(
  parameter int unsigned FW = 7
) (
  input  logic [FW-1:0] keep,
  input  logic          guard,
  input  logic          sticky,
  output logic [FW-1:0] rounded,
  output logic          carry
);

  logic          inc;
  logic [FW:0]   sum;

  // Ties go up only when the kept LSB is odd.
  assign inc = guard & (sticky | keep[0]);
  assign sum = {1'b0, keep} + {{FW{1'b0}}, inc};

  assign rounded = sum[FW-1:0];
  assign carry   = sum[FW];

endmodule

// File: rtl/frac_norm_round.sv
// Normalises an unsigned product fraction by left shifts, then rounds it to FW bits (RNE).
module frac_norm_round
  import frac_norm_round_pkg::*;
#(
  parameter int unsigned PW = ProdW,
  parameter int unsigned FW = PW / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PW-1:0]     product,
  output logic              busy,
  output logic              done,
  output logic [FW-1:0]     frac,
  output logic [ShiftW-1:0] shift,
  output logic              zero,
  output logic              sat
);

  localparam logic [ShiftW-1:0] MaxShift = ShiftW'(PW - 1);

  state_e            state_q;
  logic [PW-1:0]     work_q;
  logic [ShiftW-1:0] cnt_q;

  logic [FW-1:0]     keep;
  logic              guard;
  logic              sticky;
  logic [FW-1:0]     rounded;
  logic              carry;
  logic              work_zero;
  logic              norm_stop;

  assign keep      = work_q[PW-1 -: FW];
  assign guard     = work_q[PW-FW-1];
  assign sticky    = |work_q[PW-FW-2:0];
  assign work_zero = (work_q == '0);
  assign norm_stop = work_q[PW-1] | work_zero | (cnt_q == MaxShift);

  frac_rne_round #(
    .FW (FW)
  ) u_round (
    .keep    (keep),
    .guard   (guard),
    .sticky  (sticky),
    .rounded (rounded),
    .carry   (carry)
  );

  assign busy = (state_q == StNorm) || (state_q == StRound);
  assign done = (state_q == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      frac    <= '0;
      shift   <= '0;
      zero    <= 1'b0;
      sat     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            work_q  <= product;
            cnt_q   <= '0;
            state_q <= StNorm;
          end
        end
        StNorm: begin
          if (norm_stop) begin
            state_q <= StRound;
          end else begin
            work_q <= {work_q[PW-2:0], 1'b0};
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        StRound: begin
          if (work_zero) begin
            frac  <= '0;
            shift <= '0;
            zero  <= 1'b1;
            sat   <= 1'b0;
          end else if (carry && (cnt_q != '0)) begin
            // Carry renormalises by undoing one of the left shifts.
            frac  <= {1'b1, {(FW-1){1'b0}}};
            shift <= cnt_q - 1'b1;
            zero  <= 1'b0;
            sat   <= 1'b0;
          end else if (carry) begin
            frac  <= '1;
            shift <= '0;
            zero  <= 1'b0;
            sat   <= 1'b1;
          end else begin
            frac  <= rounded;
            shift <= cnt_q;
            zero  <= 1'b0;
            sat   <= 1'b0;
          end
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
